// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single memory-side line port between the I-cache and D-cache miss paths.
// D-cache has fixed priority; a saturating loss counter lets a starved I-cache win the next tie.
module cache_mem_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [2:0]        dbg_state,
  output logic [3:0]        dbg_starve_cnt
);

  // Handshake: a cache holds its read/write level-high until the single-cycle *_pmem_resp;
  // memory completes a transfer with a single-cycle mem_resp while mem_read/mem_write is high.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_next;
  logic [3:0]        starve_cnt, starve_next;
  logic [ADDR_W-1:0] lat_addr, addr_next;
  logic [LINE_W-1:0] lat_wdata, wdata_next;
  logic              d_pend;
  logic              starved;
  logic              i_win;

  assign d_pend  = d_pmem_read | d_pmem_write;
  assign starved = (starve_cnt == LIMIT);
  assign i_win   = i_pmem_read & (~d_pend | starved);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      lat_addr   <= addr_next;
      lat_wdata  <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    addr_next   = lat_addr;
    wdata_next  = lat_wdata;
    case (state)
      IDLE: begin
        if (i_win) begin
          state_next  = I_READ;
          addr_next   = i_pmem_address;
          starve_next = '0;
        end else if (d_pend) begin
          state_next = d_pmem_write ? D_WRITE : D_READ;
          addr_next  = d_pmem_address;
          if (d_pmem_write) wdata_next = d_pmem_wdata;
          if (i_pmem_read && !starved) starve_next = starve_cnt + 4'd1;
        end
        // A loss only counts while the I-cache is actually waiting.
        if (!i_pmem_read) starve_next = '0;
      end
      I_READ, D_READ, D_WRITE: begin
        if (mem_resp) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side strobes decode straight from the state register, so reset clears them next cycle.
  assign mem_read     = (state == I_READ) || (state == D_READ);
  assign mem_write    = (state == D_WRITE);
  assign mem_address  = lat_addr;
  assign mem_wdata    = lat_wdata;

  assign i_pmem_resp  = (state == I_READ) && mem_resp;
  assign d_pmem_resp  = ((state == D_READ) || (state == D_WRITE)) && mem_resp;
  assign i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  // A simultaneous D read and writeback is a D-cache bug; the write would win.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE) assert (!(d_pmem_read && d_pmem_write));
  end

endmodule
